mem_responder: RTL
==================

Name: mem_responder

Overview:
- Memory-side responder for the cache request protocol: the end that answers dREN/dWEN/daddr/dstore from the dcache and iREN/iaddr from the icache.
- Arbitrates between the two caches, holds a fixed-latency access to the RAM and releases the winner by dropping its wait line for one cycle.
- dcache has priority, with a bounded-starvation guard for the icache.
- Sits between both cache control FSMs and the single-port RAM.

Parameters:
- LAT, 2, RAM access cycles per word; legal range 1..15.
- STARVE, 4, consecutive dcache grants allowed while iREN is pending before the icache is forced in; legal range 1..15.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- iREN  in  1  icache read request.
- iaddr  in  32  icache word address.
- dREN  in  1  dcache read request.
- dWEN  in  1  dcache write request.
- daddr  in  32  dcache word address.
- dstore  in  32  dcache write data.
- iwait  out  1  low for exactly one cycle when the icache access completes.
- dwait  out  1  low for exactly one cycle when the dcache access completes.
- iload  out  32  icache read data, valid while iwait=0.
- dload  out  32  dcache read data, valid while dwait=0 on a read.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data, combinational from ramaddr.
- proto_err  out  1  one-cycle pulse on an illegal request (dREN and dWEN both high).

Behaviour:
- Reset (RST high at a rising edge): state=IDLE, counter=0, dstreak=0. Outputs: iwait=1, dwait=1, iload=0, dload=0, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, proto_err=0. RST asserted mid-access aborts the access: no wait pulse, no RAM write.
- Handshake: the requester holds its enable, address and data until its wait line is low. The wait line is high in every other cycle, including cycles with no request.
- States: IDLE, DACC, IACC.
- IDLE:
  - If dREN|dWEN and not (iREN && dstreak==STARVE), go to DACC: latch daddr, dstore, op (write if dWEN), counter=LAT-1.
  - Else if iREN, go to IACC: latch iaddr, counter=LAT-1, dstreak=0.
  - If dREN&dWEN: op=write and proto_err=1 for that cycle.
- DACC:
  - ramaddr = latched addr every cycle.
  - Read: ramREN=1 every cycle.
  - Write: ramstore = latched data every cycle; ramWEN=1 only in the final cycle (counter==0).
  - Each cycle with counter!=0: counter decrements.
  - counter==0: dwait=0, dload=ramload on a read (0 on a write). Next state IDLE. dstreak increments if iREN is high, else clears; it saturates at STARVE.
- IACC: same structure as a DACC read, using ramREN, iwait and iload. dstreak=0.
- Abort: in DACC, if dREN|dWEN drops before counter==0, return to IDLE next cycle with no wait pulse and no ramWEN. IACC aborts the same way on iREN low.
- Latency: request first seen in IDLE in cycle t; wait is low in cycle t+LAT; a new request is first seen in IDLE at t+LAT+1. With LAT=1 the completion cycle is the first DACC/IACC cycle.
- Address or data changes during an access are ignored; the latched values are used.
- The two wait lines are never low in the same cycle. The block is never in IDLE while ramREN or ramWEN is high.

Test Plan:
- dREN=1, daddr=0x100, ramload=0xDEADBEEF, LAT=2 -> ramREN high for 2 cycles; dwait low one cycle, 2 cycles after request seen; dload=0xDEADBEEF that cycle; iwait stays 1.
- dWEN=1, daddr=0x3100, dstore=0x12345678 -> ramWEN=1 only in the final access cycle, with ramaddr=0x3100 and ramstore=0x12345678; dwait pulses once; dload=0.
- iREN and dREN held continuously, STARVE=4 -> service order D,D,D,D,I,D,D,D,D,I; every wait pulse is one cycle wide.
- dREN=1 then dropped after 1 cycle of DACC, LAT=3 -> no dwait pulse, no ramWEN; FSM back in IDLE; a following iREN completes normally.
- dREN=dWEN=1 -> proto_err pulses 1 cycle; the access is performed as a write.
- RST high during a DACC write with counter=1 -> next cycle all outputs at reset values; ramWEN never asserted.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder
//
// Memory-side end of the cache request protocol. Arbitrates between the
// dcache (dREN/dWEN/daddr/dstore) and the icache (iREN/iaddr), runs one
// fixed-latency access to a single-port RAM at a time, and releases the
// winner by dropping its wait line for exactly one cycle.
//
// The dcache has priority. The icache is forced in after STARVE consecutive
// dcache grants that completed while iREN was pending.
//
// Parameters:
//   LAT     RAM access cycles per word (1..15)
//   STARVE  dcache grants tolerated while iREN waits (1..15)
//
// Ports:
//   CLK, RST          clock (rising edge), synchronous active-high reset
//   iREN, iaddr       icache read request and word address
//   dREN, dWEN        dcache read / write request
//   daddr, dstore     dcache word address and write data
//   iwait, dwait      low for one cycle when the respective access completes
//   iload, dload      read data, valid while the matching wait line is low
//   ramREN, ramWEN    RAM read / write strobes
//   ramaddr, ramstore RAM address and write data
//   ramload           RAM read data, combinational from ramaddr
//   proto_err         one-cycle pulse when dREN and dWEN are both high
module mem_responder #(
    parameter int LAT    = 2,
    parameter int STARVE = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        iwait,
    output logic        dwait,
    output logic [31:0] iload,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    output logic        proto_err
);

    typedef enum logic [1:0] {
        IDLE,
        DACC,
        IACC
    } state_t;

    localparam logic [3:0] LAT_M1   = 4'(LAT - 1);
    localparam logic [3:0] STARVE_V = 4'(STARVE);

    state_t      state, state_next;
    logic [3:0]  counter, counter_next;
    logic [3:0]  dstreak, dstreak_next;
    logic [31:0] addr_q, addr_next;
    logic [31:0] data_q, data_next;
    logic        write_q, write_next;

    logic        d_req;
    logic        last;

    assign d_req = dREN | dWEN;
    assign last  = (counter == 4'd0);

    // State register; reset also abandons any access in flight.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            counter <= 4'd0;
            dstreak <= 4'd0;
            addr_q  <= 32'd0;
            data_q  <= 32'd0;
            write_q <= 1'b0;
        end else begin
            state   <= state_next;
            counter <= counter_next;
            dstreak <= dstreak_next;
            addr_q  <= addr_next;
            data_q  <= data_next;
            write_q <= write_next;
        end
    end

    // Arbitration, access sequencing and all outputs.
    // A requester dropping its enable mid-access aborts it: no wait pulse
    // and, for a write, no RAM write strobe.
    always_comb begin
        state_next   = state;
        counter_next = counter;
        dstreak_next = dstreak;
        addr_next    = addr_q;
        data_next    = data_q;
        write_next   = write_q;

        iwait     = 1'b1;
        dwait     = 1'b1;
        iload     = 32'd0;
        dload     = 32'd0;
        ramREN    = 1'b0;
        ramWEN    = 1'b0;
        ramaddr   = 32'd0;
        ramstore  = 32'd0;
        proto_err = 1'b0;

        case (state)
            IDLE: begin
                // The icache wins only once the dcache has used up its streak.
                if (d_req && !(iREN && dstreak == STARVE_V)) begin
                    state_next   = DACC;
                    addr_next    = daddr;
                    data_next    = dstore;
                    write_next   = dWEN;
                    counter_next = LAT_M1;
                    proto_err    = dREN & dWEN;
                end else if (iREN) begin
                    state_next   = IACC;
                    addr_next    = iaddr;
                    counter_next = LAT_M1;
                    dstreak_next = 4'd0;
                end
            end

            DACC: begin
                ramaddr = addr_q;
                if (write_q) begin
                    ramstore = data_q;
                end else begin
                    ramREN = 1'b1;
                end
                if (!d_req) begin
                    state_next = IDLE;
                end else if (last) begin
                    dwait      = 1'b0;
                    ramWEN     = write_q;
                    dload      = write_q ? 32'd0 : ramload;
                    state_next = IDLE;
                    // Count dcache wins only while the icache is actually waiting.
                    if (iREN) begin
                        dstreak_next = (dstreak == STARVE_V) ? dstreak : dstreak + 4'd1;
                    end else begin
                        dstreak_next = 4'd0;
                    end
                end else begin
                    counter_next = counter - 4'd1;
                end
            end

            IACC: begin
                ramaddr      = addr_q;
                ramREN       = 1'b1;
                dstreak_next = 4'd0;
                if (!iREN) begin
                    state_next = IDLE;
                end else if (last) begin
                    iwait      = 1'b0;
                    iload      = ramload;
                    state_next = IDLE;
                end else begin
                    counter_next = counter - 4'd1;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule
